uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART byte transmitter among four requesters. Each requester presents a byte with a level request. The arbiter grants one requester at a time and launches the byte with a one-cycle start pulse. It then tracks the transmitter's busy flag until the frame completes before granting again. It sits between the top-level input sources (switch/debounced-button logic and future on-chip producers) and the transmitter instance that drives `uo_out[4]`.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 16: cycles to wait for `tx_busy` to rise after `tx_start`. Used only when the timeout feature is compiled in.

Ports:
- `clk`  in  1  single system clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  4  per-requester request level; bit i = requester i.
- `req_data`  in  32  packed bytes; byte i is `req_data[8*i+7:8*i]`. Must be stable while `req[i]` is high and not yet granted.
- `gnt`  out  4  one-hot, one-cycle pulse; byte i has been accepted.
- `tx_start`  out  1  one-cycle launch pulse to the transmitter.
- `tx_data`  out  8  byte to transmit; held from launch until the frame ends.
- `tx_busy`  in  1  transmitter busy flag; high while a frame is shifting.
- `owner`  out  2  index of the current or last granted requester.
- `arb_busy`  out  1  high whenever state ≠ IDLE.
- `tx_err`  out  1  one-cycle pulse on ack timeout. Tied 0 without `UART_ARB_TIMEOUT_EN`.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- **IDLE:**
  - If any `req` bit is high, select the winner by round-robin.
  - The search starts at `(last+1) mod 4` and wraps.
  - On the edge: capture the winner's byte into `tx_data`, set `owner` and `last` to the winner, and go to LAUNCH.
- **LAUNCH (1 cycle):**
  - `tx_start`=1 and `gnt[owner]`=1.
  - Next state is WAIT_BUSY.
- **WAIT_BUSY:**
  - `tx_busy` sampled high → WAIT_DONE.
- **WAIT_DONE:**
  - `tx_busy` sampled low → IDLE.
- **Requester rules:**
  - A requester keeps `req` high to queue further bytes.
  - After a grant, it may update its data in the cycle following `gnt`.
- **Fairness:**
  - A requester that was just granted has the lowest priority at the next arbitration.
  - With all four requesting continuously, the grant order is 0,1,2,3,0,...
- **`req` changes:** a `req` that drops before it is granted is ignored; nothing is latched. Changes to `req` outside IDLE have no effect on the transaction in flight.
- **`tx_busy` already high at LAUNCH:** it is sampled in WAIT_BUSY on the next cycle, and the arbiter proceeds normally.
- **Reset mid-transaction:**
  - All state clears immediately and `tx_start` falls.
  - `tx_data` is cleared even if the transmitter is still shifting; the transmitter is reset by the same `rst_n`.
- **Reset values:** `gnt`=0, `tx_start`=0, `tx_data`=8'h00, `owner`=0, `arb_busy`=0, `tx_err`=0, state=IDLE, `last`=3 (so requester 0 wins first).

## Timing
- `req[i]` sampled high at edge k in IDLE → `gnt[i]` and `tx_start` are high during cycle k+1 (exactly one cycle), and `tx_data` is valid from k+1.
- `arb_busy` rises at k+1 and falls on the edge where WAIT_DONE samples `tx_busy` low.
- Minimum launch-to-launch spacing:
  - 4 cycles with a 1-cycle busy pulse from the transmitter.
  - Otherwise, busy duration + 3 cycles.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- **`UART_ARB_TIMEOUT_EN` defined:**
  - An 8-bit counter runs in WAIT_BUSY.
  - If `tx_busy` is not seen high within `ACK_TIMEOUT` cycles after LAUNCH, the arbiter pulses `tx_err` for one cycle and returns to IDLE.
  - The byte is considered consumed, and `last` keeps the timed-out owner.
  - The counter clears on entry to WAIT_BUSY.
- **`UART_ARB_TIMEOUT_EN` not defined:**
  - WAIT_BUSY waits indefinitely.
  - `tx_err` is constant 0, and the counter logic is absent.

## Test plan
- Reset, then `req`=4'b0001, `req_data[7:0]`=8'h41, transmitter busy for 10 cycles → `gnt`=0001 and `tx_start` for one cycle, `tx_data`=8'h41, `arb_busy` high until busy falls, then IDLE.
- `req`=4'b1111 held, bytes 8'h10/8'h20/8'h30/8'h40 → grants in order 0,1,2,3,0, and `tx_data` follows 10,20,30,40,10.
- `req`=4'b0110 after last grant to 1 → next grant goes to 2, then 1.
- Assert `rst_n`=0 during WAIT_DONE → outputs go to reset values immediately; after release, arbitration restarts with requester 0 having priority.
- With `UART_ARB_TIMEOUT_EN`, `ACK_TIMEOUT`=16, and `tx_busy` stuck low → `tx_err` pulses 16 cycles after LAUNCH, and the next request is granted normally.
- `req[2]` raised then dropped before the arbiter returns to IDLE → no `gnt[2]` and no launch.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among four requesters.
// Optional ack timeout on tx_busy is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  gnt,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [1:0]  owner,
  output logic        arb_busy,
  output logic        tx_err
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  owner_q, owner_d;
  logic [7:0]  data_q, data_d;
  logic        err_q, err_d;

  logic [1:0]  win, idx;
  logic        win_vld;
  logic        to_hit;

  // Search starts one past the last winner, so the last winner ranks lowest.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int j = 1; j <= 4; j++) begin
      idx = last_q + 2'(j);
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Expiry lands tx_err exactly ACK_TIMEOUT cycles after the LAUNCH cycle.
  localparam logic [7:0] TO_LIM = (ACK_TIMEOUT >= 2) ? 8'(ACK_TIMEOUT - 2) : 8'd0;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT_BUSY) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign to_hit = (state_q == WAIT_BUSY) && (cnt_q >= TO_LIM);
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    data_d  = data_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          data_d  = req_data[8*win +: 8];
          owner_d = win;
          last_d  = win;
          state_d = LAUNCH;
        end
      end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      owner_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign tx_start = (state_q == LAUNCH);
  assign gnt      = tx_start ? (4'b0001 << owner_q) : 4'b0000;
  assign arb_busy = (state_q != IDLE);
  assign tx_data  = data_q;
  assign owner    = owner_q;
  assign tx_err   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter with a queue-free round-robin model
// and a simple transmitter emulation that answers tx_start with a delayed busy window.
module tb_uart_tx_arbiter;
  localparam int ACK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  gnt;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  owner;
  logic        arb_busy;
  logic        tx_err;

  uart_tx_arbiter #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .owner(owner),
    .arb_busy(arb_busy), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int m_last = 3;
  int xm_dly = 1, xm_len = 1;
  bit xm_stuck = 1'b0;
  int lo_own;
  logic [7:0] lo_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] r);
    for (int j = 1; j <= 4; j++)
      if (r[(last + j) % 4]) return (last + j) % 4;
    return -1;
  endfunction

  // Transmitter emulation: busy rises xm_dly cycles after the launch is seen, lasts xm_len.
  initial begin
    int wait_c, run_c;
    wait_c = 0; run_c = 0; tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        wait_c = 0; run_c = 0; tx_busy = 1'b0;
      end else begin
        if (tx_start && !xm_stuck) begin
          wait_c = xm_dly; run_c = xm_len;
        end
        if (wait_c > 0) begin
          wait_c--; tx_busy = 1'b0;
        end else if (run_c > 0) begin
          run_c--; tx_busy = 1'b1;
        end else begin
          tx_busy = 1'b0;
        end
      end
    end
  end

  // One arbitration from an IDLE cycle. noise: 0 hold req, 1 random req in flight,
  // 2 raise req[2] briefly in flight then drop all requests.
  task automatic do_txn(input logic [3:0] r, input int d, input int len, input int noise);
    int w, n, bad;
    logic [7:0] eb;
    xm_dly = d; xm_len = len; req = r;
    step();
    w = rr_pick(m_last, r);
    if (w < 0) begin
      chk("idle_start", tx_start, 0);
      chk("idle_abusy", arb_busy, 0);
    end else begin
      eb = req_data[8*w +: 8];
      chk("gnt", gnt, 32'(4'b0001 << w));
      chk("start", tx_start, 1);
      chk("data", tx_data, eb);
      chk("owner", owner, w);
      chk("abusy", arb_busy, 1);
      lo_own = owner; lo_data = tx_data;
      m_last = w;
      n = 0; bad = 0;
      do begin
        if (noise == 1) req = 4'($urandom);
        if (noise == 2) req = (n < 2) ? 4'b0100 : 4'b0000;
        step(); n++;
        if (tx_start || gnt != 4'b0000 || tx_data !== eb) bad++;
      end while (arb_busy && n < 60);
      chk("flight_len", n, d + len + 1);
      chk("flight_stable", bad, 0);
    end
  endtask

  initial begin
    int d, len, n;
    logic [3:0] r, rprev;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_owner", owner, 0);
    chk("rst_abusy", arb_busy, 0);
    chk("rst_err", tx_err, 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // All four requesting at minimum spacing: order 0,1,2,3,0.
    req_data = 32'h40302010;
    for (int k = 0; k < 5; k++) begin
      do_txn(4'b1111, 1, 1, 0);
      chk("seq_order", lo_own, k % 4);
      chk("seq_data", lo_data, 8'h10 * ((k % 4) + 1));
    end

    req_data = 32'h00000041;
    do_txn(4'b0001, 1, 10, 0);

    req_data = 32'h00C3B2A1;
    do_txn(4'b0010, 1, 2, 0);
    do_txn(4'b0110, 1, 2, 0);
    chk("rr_0110_a", lo_own, 2);
    do_txn(4'b0110, 1, 2, 0);
    chk("rr_0110_b", lo_own, 1);

    // Busy already high during LAUNCH.
    req_data = 32'h5A000000;
    do_txn(4'b1000, 0, 3, 0);

    // A request withdrawn before IDLE is never granted.
    req_data = 32'h00770011;
    do_txn(4'b0001, 1, 4, 2);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drop_start", tx_start, 0);
      chk("drop_gnt2", gnt[2], 0);
    end

    rprev = '0;
    for (int t = 0; t < 150; t++) begin
      r = 4'($urandom);
      for (int i = 0; i < 4; i++)
        if (!rprev[i] || i == m_last) req_data[8*i +: 8] = 8'($urandom);
      d = $urandom_range(0, 3);
      len = $urandom_range((d == 0) ? 2 : 1, 6);
      do_txn(r, d, len, 1);
      rprev = r;
    end

    // Reset during WAIT_DONE.
    req = '0;
    step();
    req_data = 32'h00990000;
    xm_dly = 1; xm_len = 10; req = 4'b0100;
    step();
    chk("rwd_start", tx_start, 1);
    repeat (3) step();
    chk("rwd_pre_abusy", arb_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rwd_data", tx_data, 0);
    chk("rwd_owner", owner, 0);
    chk("rwd_abusy", arb_busy, 0);
    chk("rwd_start0", tx_start, 0);
    chk("rwd_gnt", gnt, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    m_last = 3;
    req_data = 32'hDDCCBBAA;
    do_txn(4'b1111, 1, 2, 0);
    chk("rwd_first_own", lo_own, 0);

`ifdef UART_ARB_TIMEOUT_EN
    xm_stuck = 1'b1;
    req = 4'b0001;
    step();
    chk("to_start", tx_start, 1);
    m_last = 0;
    req = 4'b0000;
    n = 0;
    do begin step(); n++; end while (!tx_err && n < 40);
    chk("to_cycles", n, ACK_TIMEOUT);
    chk("to_abusy", arb_busy, 0);
    step();
    chk("to_pulse", tx_err, 0);
    xm_stuck = 1'b0;
    do_txn(4'b0011, 1, 2, 0);
    chk("to_next_own", lo_own, 1);
`else
    chk("err_tied", tx_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
